// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// default bit period (100 MHz clock, 115200 baud).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StRecover
    } uart_rx_state_t;

    // Even-parity check: returns 1 when data plus parity bit has an odd number of ones.
    function automatic logic parity_odd(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit. The reset
// value is a parameter so idle-high lines (UART RX) come out of reset idle.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Bytes are presented on rx_data_o with a one-cycle rx_valid_o strobe; bad
// frames produce a one-cycle frame_error_o or parity_error_o strobe instead.
// IDLE is re-entered at the middle of the stop bit so the next start edge,
// half a bit later, is never missed.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rxd_i,
    output logic [UART_DATA_BITS-1:0] rx_data_o,
    output logic                      rx_valid_o,
    output logic                      frame_error_o,
    output logic                      parity_error_o,
    output logic                      busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned Half = CLKS_PER_BIT / 2;

    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LastBit  = 3'(UART_DATA_BITS - 1);

    logic rxd_s;

    uart_rx_state_t            state_q;
    logic [CntW-1:0]           cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] rx_data_q;
    logic                      rx_valid_q;
    logic                      frame_error_q;

    logic half_end;
    logic bit_end;

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (rxd_i),
        .q_o    (rxd_s)
    );

    assign half_end = (cnt_q == HalfLast);
    assign bit_end  = (cnt_q == BitLast);

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q;
    logic parity_error_q;
`endif

    // Receive FSM: bit timing, sampling, shifting and registered strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q   <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle by default.
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (!rxd_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end

                StStart: begin
                    if (half_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid-start means a glitch, not a frame.
                        state_q   <= rxd_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        cnt_q        <= '0;
                        parity_bit_q <= rxd_s;
                        state_q      <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
                            if (parity_odd(shift_q, parity_bit_q)) begin
                                parity_error_q <= 1'b1;
                            end else begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end
`else
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
`endif
                        end else begin
                            // A low stop bit outranks any parity problem.
                            frame_error_q <= 1'b1;
                            state_q       <= StRecover;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRecover: begin
                    // Wait out a break so a held-low line cannot look like a new start.
                    if (rxd_s) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_error_o = frame_error_q;
    assign busy_o        = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
    assign parity_error_o = parity_error_q;
`else
    assign parity_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (16 and 17 clocks per bit) fed by a
// behavioural serial transmitter; expected bytes and error strobes come from
// a frame-level model and are compared against the strobes each receiver emits.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int Cpb16 = 16;
    localparam int Cpb17 = 17;

    // Event kinds seen at the receiver output.
    localparam int EvByte   = 0;
    localparam int EvFrame  = 1;
    localparam int EvParity = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rxd16   = 1'b1;
    logic rxd17   = 1'b1;

    logic [7:0] rx_data16, rx_data17;
    logic       rx_valid16, rx_valid17;
    logic       frame_error16, frame_error17;
    logic       parity_error16, parity_error17;
    logic       busy16, busy17;

    int checks = 0;
    int errors = 0;

    int unsigned cyc         = 0;
    int unsigned start_cyc16 = 0;
    int unsigned valid_cyc16 = 0;

    ev_t obs16[$];
    ev_t obs17[$];
    ev_t exp16[$];
    ev_t exp17[$];

    logic [7:0] last16 = 8'h00;
    logic [7:0] last17 = 8'h00;

    logic prev_any16 = 1'b0;
    logic prev_any17 = 1'b0;

    wire any16 = rx_valid16 | frame_error16 | parity_error16;
    wire any17 = rx_valid17 | frame_error17 | parity_error17;

    uart_rx #(
        .CLKS_PER_BIT(Cpb16)
    ) u_dut16 (
        .clk           (clk),
        .reset_n       (reset_n),
        .rxd_i         (rxd16),
        .rx_data_o     (rx_data16),
        .rx_valid_o    (rx_valid16),
        .frame_error_o (frame_error16),
        .parity_error_o(parity_error16),
        .busy_o        (busy16)
    );

    uart_rx #(
        .CLKS_PER_BIT(Cpb17)
    ) u_dut17 (
        .clk           (clk),
        .reset_n       (reset_n),
        .rxd_i         (rxd17),
        .rx_data_o     (rx_data17),
        .rx_valid_o    (rx_valid17),
        .frame_error_o (frame_error17),
        .parity_error_o(parity_error17),
        .busy_o        (busy17)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Output monitors: collect strobes, check exclusivity and single-cycle width.
    always @(negedge clk) begin
        if (any16) begin
            chk("onehot16", 32'($onehot({rx_valid16, frame_error16, parity_error16})), 1);
            chk("width16", 32'(prev_any16), 0);
            if (rx_valid16) begin
                obs16.push_back('{kind: EvByte, data: rx_data16});
                valid_cyc16 <= cyc;
            end
            if (frame_error16) obs16.push_back('{kind: EvFrame, data: 8'h00});
            if (parity_error16) obs16.push_back('{kind: EvParity, data: 8'h00});
        end
        prev_any16 <= any16;
    end

    always @(negedge clk) begin
        if (any17) begin
            chk("onehot17", 32'($onehot({rx_valid17, frame_error17, parity_error17})), 1);
            chk("width17", 32'(prev_any17), 0);
            if (rx_valid17) obs17.push_back('{kind: EvByte, data: rx_data17});
            if (frame_error17) obs17.push_back('{kind: EvFrame, data: 8'h00});
            if (parity_error17) obs17.push_back('{kind: EvParity, data: 8'h00});
        end
        prev_any17 <= any17;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rxd17 = b;
        else rxd16 = b;
    endtask

    // Frame-level model: what the receiver should report for one transmitted frame.
    task automatic model_frame(input bit sel, input logic [7:0] data, input bit par_flip,
                               input bit stop_bit);
        ev_t e;
        e.data = 8'h00;
        if (!stop_bit) begin
            e.kind = EvFrame;
        end else if (ParityEn && par_flip) begin
            e.kind = EvParity;
        end else begin
            e.kind = EvByte;
            e.data = data;
            if (sel) last17 = data;
            else last16 = data;
        end
        if (sel) exp17.push_back(e);
        else exp16.push_back(e);
    endtask

    // Serial transmitter; pct scales the bit period (100 = nominal baud).
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_flip,
                              input bit stop_bit, input int pct);
        logic bits[$];
        int   cpb;
        int   t0;
        int   t1;
        cpb = sel ? Cpb17 : Cpb16;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (ParityEn) bits.push_back((^data) ^ par_flip);
        bits.push_back(stop_bit);
        model_frame(sel, data, par_flip, stop_bit);
        if (!sel) start_cyc16 = cyc;
        for (int k = 0; k < bits.size(); k++) begin
            t0 = (k * cpb * pct + 50) / 100;
            t1 = ((k + 1) * cpb * pct + 50) / 100;
            drive(sel, bits[k]);
            idle(t1 - t0);
        end
    endtask

    task automatic check_events(input bit sel, input string tag);
        ev_t        o[$];
        ev_t        e[$];
        int         n;
        logic [7:0] cur;
        logic [7:0] want;
        if (sel) begin
            o = obs17;
            e = exp17;
            obs17.delete();
            exp17.delete();
            cur  = rx_data17;
            want = last17;
        end else begin
            o = obs16;
            e = exp16;
            obs16.delete();
            exp16.delete();
            cur  = rx_data16;
            want = last16;
        end
        chk({tag, "_count"}, o.size(), e.size());
        n = (o.size() < e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, o[i].kind, e[i].kind);
            if (e[i].kind == EvByte) chk({tag, "_data"}, o[i].data, e[i].data);
        end
        chk({tag, "_hold"}, cur, want);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data16"}, rx_data16, 0);
        chk({tag, "_valid16"}, rx_valid16, 0);
        chk({tag, "_ferr16"}, frame_error16, 0);
        chk({tag, "_perr16"}, parity_error16, 0);
        chk({tag, "_busy16"}, busy16, 0);
        chk({tag, "_data17"}, rx_data17, 0);
        chk({tag, "_busy17"}, busy17, 0);
    endtask

    initial begin
        int          lat;
        int          lat_exp;
        logic [7:0]  d;
        bit          stop_b;
        bit          flip;

        // Reset values.
        @(posedge clk);
        #1;
        idle(4);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(10);

        // Back-to-back frames with a one-bit stop.
        send_frame(0, 8'h55, 0, 1, 100);
        send_frame(0, 8'hA3, 0, 1, 100);
        idle(40);
        check_events(0, "b2b");

        // Five-cycle low glitch: START entered, then abandoned at mid-start.
        rxd16 = 1'b0;
        idle(5);
        rxd16 = 1'b1;
        @(negedge clk);
        chk("glitch_busy", busy16, 1);
        @(posedge clk);
        #1;
        idle(30);
        @(negedge clk);
        chk("glitch_idle", busy16, 0);
        @(posedge clk);
        #1;
        check_events(0, "glitch");

        // Low stop bit followed by a break; receiver waits in RECOVER.
        send_frame(0, 8'h3C, 0, 0, 100);
        idle(40);
        @(negedge clk);
        chk("recover_busy", busy16, 1);
        @(posedge clk);
        #1;
        rxd16 = 1'b1;
        idle(5);
        @(negedge clk);
        chk("recover_exit", busy16, 0);
        @(posedge clk);
        #1;
        check_events(0, "ferr");

        // Clean frame after the break, with strobe latency from the start edge.
        send_frame(0, 8'h81, 0, 1, 100);
        idle(40);
        check_events(0, "after_break");
        lat     = int'(valid_cyc16 - start_cyc16);
        lat_exp = 3 + Cpb16 / 2 + 9 * Cpb16 + (ParityEn ? Cpb16 : 0);
        chk("latency", 32'(lat >= lat_exp - 1 && lat <= lat_exp + 1), 1);

`ifdef UART_RX_PARITY_EN
        // Good parity then bad parity; the bad one leaves rx_data at 0x07.
        send_frame(0, 8'h07, 0, 1, 100);
        idle(20);
        check_events(0, "par_good");
        send_frame(0, 8'h07, 1, 1, 100);
        idle(20);
        check_events(0, "par_bad");
        // Parity and framing both bad: framing wins.
        send_frame(0, 8'hC4, 1, 0, 100);
        idle(10);
        rxd16 = 1'b1;
        idle(40);
        check_events(0, "par_and_frame");
`endif

        // Reset pulse in the middle of data bit 4 of an 0xFF frame.
        rxd16 = 1'b0;
        idle(Cpb16);
        rxd16 = 1'b1;
        idle(4 * Cpb16 + Cpb16 / 2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        last16  = 8'h00;
        last17  = 8'h00;
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        idle(6 * Cpb16);
        check_events(0, "midreset_quiet");
        send_frame(0, 8'h12, 0, 1, 100);
        idle(40);
        check_events(0, "post_reset");

        // 17 clocks per bit, transmitter 3% slow then 3% fast.
        send_frame(1, 8'h5A, 0, 1, 97);
        idle(40);
        check_events(1, "baud_slow");
        send_frame(1, 8'h5A, 0, 1, 103);
        idle(40);
        check_events(1, "baud_fast");

        // Randomized frames: data, stop validity, parity corruption, baud and gaps.
        for (int n = 0; n < 24; n++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            flip   = ParityEn && ($urandom_range(0, 3) == 0);
            send_frame(0, d, flip, stop_b, $urandom_range(97, 103));
            if (!stop_b) begin
                idle($urandom_range(0, 20));
                rxd16 = 1'b1;
                idle(2 * Cpb16);
            end else begin
                idle($urandom_range(0, 12));
            end
            if (n % 6 == 5) begin
                idle(40);
                check_events(0, "random");
            end
        end
        idle(40);
        check_events(0, "random_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deserialises 8N1 UART frames from the board's RX pin into bytes, each delivered with a one-cycle strobe. It sits directly upstream of the stdin byte buffer: `rx_data`/`rx_valid` drive that buffer's write data/write enable, so every accepted byte is appended in arrival order. Start-bit validation, mid-bit sampling and stop-bit checking happen here, so the buffer only ever sees clean bytes.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clk cycles per bit period; legal range 4 or more.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `rxd`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  last received byte; holds until the next accepted byte.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is new this cycle.
- `frame_error`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_error`  out  1  one-cycle strobe: parity mismatch (see Configuration).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer, giving `rxd_s`. All logic uses `rxd_s`.
- HALF = CLKS_PER_BIT/2, using integer division. The bit counter width is $clog2(CLKS_PER_BIT).
- State machine:
  - IDLE: when `rxd_s`==0, go to START and clear the counter.
  - START: count 0..HALF-1. At HALF-1, sample `rxd_s`.
    - If 1 (glitch or false start), return to IDLE with no output.
    - If 0, go to DATA with bit index 0 and the counter cleared.
  - DATA: count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift `rxd_s` into the shift register (LSB first) and clear the counter.
    - After bit 7, go to PARITY if the parity feature is enabled, otherwise to STOP.
  - PARITY: same timing as DATA. Samples one bit, then goes to STOP.
  - STOP: same timing. At the sample point:
    - `rxd_s`==1 and no parity error: load `rx_data`, pulse `rx_valid`, go to IDLE.
    - `rxd_s`==1 with a parity error: pulse `parity_error`, go to IDLE, leave `rx_data` unchanged.
    - `rxd_s`==0: pulse `frame_error`, go to RECOVER, drop the byte.
  - RECOVER: wait until `rxd_s`==1, then go to IDLE. This stops a break condition from re-triggering START.
- A parity error and a frame error in the same frame report `frame_error` only.
- IDLE is re-entered at mid-stop-bit. A start edge arriving half a bit later is therefore caught.
- `rx_valid`, `frame_error` and `parity_error` are mutually exclusive and never held high for more than one cycle.

## Timing
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `frame_error`=0, `parity_error`=0, `busy`=0, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately. The partial byte is discarded and no strobe is produced.
- Pin-to-detect latency is 2 cycles (synchronizer). START is entered on the next edge.
- The `rx_valid` edge occurs HALF + 8·CLKS_PER_BIT (+CLKS_PER_BIT with parity) + CLKS_PER_BIT cycles after START entry, ±1 cycle.
- Strobes and `rx_data` are registered. `rx_data` is stable in the same cycle that `rx_valid` is high.
- There is no backpressure. The consumer must accept a byte in the cycle of `rx_valid`.

## Configuration
- `UART_RX_PARITY_EN`, defined:
  - The frame is 8E1. The PARITY state exists.
  - Error condition: XOR of the 8 data bits and the parity bit equals 1. This drops the byte and pulses `parity_error`.
- `UART_RX_PARITY_EN`, undefined:
  - The frame is 8N1. The PARITY state is not compiled.
  - `parity_error` is tied to 0.

## Structure
- The shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, RECOVER);
  - `UART_DATA_BITS`=8;
  - the default `CLKS_PER_BIT` constant.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with reset value as a parameter (1 here).

## Test plan
- CLKS_PER_BIT=16. Send 0x55, then 0xA3 back-to-back, with a stop length of exactly 1 bit. Expect two `rx_valid` pulses with `rx_data` 0x55, then 0xA3, and no error strobes.
- Drive a 5-cycle low glitch on idle `rxd`. Expect a return to IDLE after the START sample, with no strobes and `busy` low again.
- Send 0x3C with the stop bit low, then hold `rxd` low for 40 cycles. Expect exactly one `frame_error` pulse, no `rx_valid`, and the block staying in RECOVER until `rxd` rises. A following 0x81 is received correctly.
- With `UART_RX_PARITY_EN`:
  - Send 0x07 with parity bit 1. Expect `rx_valid` with 0x07.
  - Send 0x07 with parity bit 0. Expect `parity_error`, and `rx_data` still 0x07 from the prior byte.
- Assert `reset_n` low for 1 cycle at data bit 4 of a 0xFF frame. Expect all outputs at their reset values and no strobe for that frame. The next 0x12 frame is received correctly.
- Run with CLKS_PER_BIT=17 and the transmitter at ±3% baud. Expect 0x5A received correctly in both cases.
